// File: rtl/alu_muldiv_hilo_if.sv
// Issue/result bundle between the execute stage and the HI/LO multiply/divide unit.
// The master side issues ops and watches busy/done; the slave side is the unit itself.
interface alu_muldiv_hilo_if #(
    parameter int DATA_W = 32
) ();
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              cancel;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, data1, data2, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, data1, data2, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_hilo.sv
// Multi-cycle multiply / restoring divide unit that owns the HI/LO register pair.
// Multiplies complete after MUL_DELAY busy cycles, divides after DATA_W+1 busy cycles.
module alu_muldiv_hilo #(
    parameter int DATA_W    = 32,
    parameter int MUL_DELAY = 4
) (
    input logic              clock,
    input logic              reset,
    alu_muldiv_hilo_if.slave bus
);
    localparam int CNT_MAX = (MUL_DELAY > DATA_W + 1) ? MUL_DELAY : DATA_W + 1;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DIV_FIX} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [DATA_W-1:0]        op_a, op_b, quo, rem;
    logic                     sgn;
    logic [DATA_W-1:0]        hi_r, lo_r;
    logic                     done_r;
    logic                     accept, is_mul, is_div, res_wr, mul_wr;
    logic signed [2*DATA_W-1:0] mul_a, mul_b, mul_p;
    logic [DATA_W-1:0]        dvs, fix_q, fix_r;
    logic [DATA_W:0]          div_sh, div_diff;

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic c);
        return c ? (~v + DATA_W'(1)) : v;
    endfunction

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic s);
        return neg_if(v, s && v[DATA_W-1]);
    endfunction

    assign is_mul   = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign is_div   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign accept   = bus.start && !bus.cancel && (state == IDLE);
    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Product is formed from the latched operands; only the final edge captures it.
    always_comb begin
        mul_a = sgn ? {{DATA_W{op_a[DATA_W-1]}}, op_a} : {{DATA_W{1'b0}}, op_a};
        mul_b = sgn ? {{DATA_W{op_b[DATA_W-1]}}, op_b} : {{DATA_W{1'b0}}, op_b};
        mul_p = mul_a * mul_b;
    end

    // Restoring step on magnitudes; a zero divisor bypasses sign correction entirely.
    always_comb begin
        dvs      = mag(op_b, sgn);
        div_sh   = {rem, quo[DATA_W-1]};
        div_diff = div_sh - {1'b0, dvs};
        if (op_b == '0) begin
            fix_q = '1;
            fix_r = op_a;
        end else begin
            fix_q = neg_if(quo, sgn && (op_a[DATA_W-1] ^ op_b[DATA_W-1]));
            fix_r = neg_if(rem, sgn && op_a[DATA_W-1]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        res_wr    = 1'b0;
        mul_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_mul)      state_nxt = MUL;
                else if (accept && is_div) state_nxt = DIV;
            end
            MUL: begin
                if (bus.cancel) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                    res_wr    = 1'b1;
                    mul_wr    = 1'b1;
                end
            end
            DIV: begin
                if (bus.cancel)      state_nxt = IDLE;
                else if (cnt == '0)  state_nxt = DIV_FIX;
            end
            DIV_FIX: begin
                state_nxt = IDLE;
                res_wr    = !bus.cancel;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            quo    <= '0;
            rem    <= '0;
            sgn    <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= res_wr;
            if (accept) begin
                case (bus.op)
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        op_a <= bus.data1;
                        op_b <= bus.data2;
                        sgn  <= (bus.op == OP_MULT) || (bus.op == OP_DIV);
                        rem  <= '0;
                        quo  <= mag(bus.data1, bus.op == OP_DIV);
                        cnt  <= is_mul ? CNT_W'(MUL_DELAY - 1) : CNT_W'(DATA_W - 1);
                    end
                    OP_MTHI: hi_r <= bus.data1;
                    OP_MTLO: lo_r <= bus.data1;
                    default: ;
                endcase
            end else if ((state == MUL) || (state == DIV)) begin
                if (cnt != '0) cnt <= cnt - CNT_W'(1);
                if (state == DIV) begin
                    if (!div_diff[DATA_W]) begin
                        rem <= div_diff[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        rem <= div_sh[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b0};
                    end
                end
            end
            if (res_wr) begin
                if (mul_wr) begin
                    {hi_r, lo_r} <= mul_p;
                end else begin
                    hi_r <= fix_r;
                    lo_r <= fix_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv_hilo.sv
// Bench for alu_muldiv_hilo: directed corner cases followed by randomized ops,
// all compared against an arithmetic reference model of HI/LO and busy latency.
module tb_alu_muldiv_hilo;
    localparam int W  = 4;
    localparam int MD = 2;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic         clock = 1'b0;
    logic         reset;
    int           n_chk  = 0;
    int           n_pass = 0;
    logic [W-1:0] m_hi, m_lo;

    alu_muldiv_hilo_if #(.DATA_W(W)) bus ();

    alu_muldiv_hilo #(.DATA_W(W), .MUL_DELAY(MD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        return v[W-1] ? longint'(v) - (longint'(1) << W) : longint'(v);
    endfunction

    // Architectural result of one op, from plain integer arithmetic.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el);
        longint p;
        eh = m_hi;
        el = m_lo;
        case (o)
            OP_MULT, OP_MULTU: begin
                p  = (o == OP_MULT) ? sx(a) * sx(b) : longint'(a) * longint'(b);
                eh = W'(p >>> W);
                el = W'(p);
            end
            OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                    el = '1;
                    eh = a;
                end else if (o == OP_DIVU) begin
                    el = W'(longint'(a) / longint'(b));
                    eh = W'(longint'(a) % longint'(b));
                end else if (sx(a) == -(longint'(1) << (W - 1)) && sx(b) == -1) begin
                    el = a;
                    eh = '0;
                end else begin
                    el = W'(sx(a) / sx(b));
                    eh = W'(sx(a) % sx(b));
                end
            end
            OP_MTHI: eh = a;
            OP_MTLO: el = a;
            default: ;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int cancel_at, input bit poke);
        logic [W-1:0] eh, el;
        int  lat, busy_cnt;
        bit  seen, stable;
        model(o, a, b, eh, el);
        lat = (o == OP_MULT || o == OP_MULTU) ? MD :
              (o == OP_DIV || o == OP_DIVU) ? W + 1 : 0;
        @(negedge clock);
        bus.start = 1'b1; bus.op = o; bus.data1 = a; bus.data2 = b;
        @(negedge clock);
        bus.start = 1'b0; bus.op = OP_NONE;
        if (lat == 0) begin
            check("imm_busy", bus.busy, 0);
            check("imm_done", bus.done, 0);
            check("imm_hi", bus.hi, eh);
            check("imm_lo", bus.lo, el);
            m_hi = eh; m_lo = el;
            return;
        end
        busy_cnt = 0; seen = 0; stable = 1;
        for (int k = 0; k < 64; k++) begin
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (!bus.busy) break;
            busy_cnt++;
            if (bus.hi != m_hi || bus.lo != m_lo) stable = 0;
            bus.start  = poke && (busy_cnt == 1);
            bus.op     = (poke && busy_cnt == 1) ? OP_MULTU : OP_NONE;
            bus.data1  = 4'h5;
            bus.data2  = 4'h3;
            bus.cancel = (busy_cnt == cancel_at);
            @(negedge clock);
        end
        bus.start = 1'b0; bus.op = OP_NONE; bus.cancel = 1'b0;
        check("hold_stable", stable, 1);
        if (cancel_at > 0) begin
            check("cancel_busy_cycles", busy_cnt, cancel_at);
            check("cancel_no_done", seen, 0);
            check("cancel_busy", bus.busy, 0);
            check("cancel_hi", bus.hi, m_hi);
            check("cancel_lo", bus.lo, m_lo);
        end else begin
            check("done_seen", seen, 1);
            check("busy_cycles", busy_cnt, lat);
            check("busy_at_done", bus.busy, 0);
            check("res_hi", bus.hi, eh);
            check("res_lo", bus.lo, el);
            m_hi = eh; m_lo = el;
            @(negedge clock);
            check("done_pulse", bus.done, 0);
        end
    endtask

    initial begin
        int o, ca;
        bus.start = 1'b0; bus.op = OP_NONE; bus.data1 = '0; bus.data2 = '0; bus.cancel = 1'b0;
        reset = 1'b1; m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        reset = 1'b0;

        do_op(OP_MULTU, 4'hA, 4'hA, 0, 0);
        do_op(OP_MULT,  4'hA, 4'h3, 0, 1);
        do_op(OP_DIVU,  4'h7, 4'h3, 0, 0);
        do_op(OP_DIV,   4'h9, 4'h2, 0, 0);
        do_op(OP_DIV,   4'h8, 4'hF, 0, 0);
        do_op(OP_DIVU,  4'h5, 4'h0, 0, 0);
        do_op(OP_DIV,   4'h5, 4'h0, 0, 0);

        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.data1 = 4'hA;
        @(negedge clock);
        check("mthi_vis", bus.hi, 4'hA);
        bus.op = OP_MTLO; bus.data1 = 4'h5;
        @(negedge clock);
        bus.start = 1'b0; bus.op = OP_NONE;
        check("mt_hi", bus.hi, 4'hA);
        check("mt_lo", bus.lo, 4'h5);
        check("mt_done", bus.done, 0);
        check("mt_busy", bus.busy, 0);
        m_hi = 4'hA; m_lo = 4'h5;
        do_op(OP_DIV, 4'h7, 4'h3, 2, 0);

        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.data1 = 4'h3; bus.cancel = 1'b1;
        @(negedge clock);
        bus.start = 1'b0; bus.op = OP_NONE; bus.cancel = 1'b0;
        check("cancel_start_hi", bus.hi, m_hi);
        check("cancel_start_busy", bus.busy, 0);
        do_op(OP_NONE, 4'h1, 4'h2, 0, 0);
        do_op(OP_RSVD, 4'h1, 4'h2, 0, 0);

        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.data1 = 4'hF; bus.data2 = 4'hF;
        @(negedge clock);
        bus.start = 1'b0; bus.op = OP_NONE;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        m_hi = '0; m_lo = '0;
        do_op(OP_MULTU, 4'hF, 4'hF, 0, 0);

        for (int i = 0; i < 80; i++) begin
            o  = $urandom_range(0, 7);
            ca = 0;
            if ((o >= 1 && o <= 4) && $urandom_range(0, 7) == 0)
                ca = $urandom_range(1, (o <= 2) ? MD : W + 1);
            do_op(3'(o), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ca, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_hilo.md
Name: alu_muldiv_hilo

Overview:
Parametrised multi-cycle multiply/divide unit owning the architectural HI/LO register pair; successor to the fixed-delay HI/LO ALU. Adds signed/unsigned divide, signed multiply, a busy/done handshake and cancel for pipeline flush. Sits beside the execute-stage ALU. The hazard unit stalls MFHI/MFLO and new mul/div issue while busy is high.

Parameters:
DATA_W, 32, operand and HI/LO width (>=4).
MUL_DELAY, 4, multiply latency in cycles from accept to result (>=1).

Ports:
clock  in  1  sole clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  issue op this cycle.
op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
data1  in  DATA_W  multiplicand / dividend / mthi-mtlo source.
data2  in  DATA_W  multiplier / divisor.
cancel  in  1  abort the in-flight op (exception flush).
busy  out  1  op in flight; start is not accepted.
done  out  1  one-cycle pulse; hi/lo hold the new result that cycle.
hi  out  DATA_W  HI register (MFHI source).
lo  out  DATA_W  LO register (MFLO source).

Behaviour:
- Reset (sampled at edge, overrides everything, including mid-op): hi=0, lo=0, busy=0, done=0, state IDLE, operand and counter registers cleared.
- States: IDLE, MUL, DIV, DIV_FIX. Transitions:
  - IDLE -> MUL on accepted mult/multu.
  - IDLE -> DIV on accepted div/divu.
  - MUL -> IDLE after MUL_DELAY cycles.
  - DIV -> DIV_FIX after DATA_W iterations.
  - DIV_FIX -> IDLE.
- Accept: start=1 and state IDLE and cancel=0. Operands and signedness are latched at accept.
  - start while busy: ignored, no effect.
  - cancel and start in the same cycle: cancel wins; op dropped.
- busy rises in the cycle after accept.
  - mult/multu: busy high for exactly MUL_DELAY cycles.
  - div/divu: busy high for exactly DATA_W+1 cycles.
- On the final busy cycle's edge, {hi,lo} are written. busy falls and done=1 in the following cycle. done is high for one cycle only.
- mult: signed 2*DATA_W product. multu: unsigned product. hi = upper half, lo = lower half.
- div/divu: restoring division on magnitudes, one quotient bit per cycle, sign correction in DIV_FIX. lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Overflow case (most-negative / -1): lo = most-negative, hi = 0. No trap.
  - Divide by zero (both signednesses): lo = all ones, hi = data1. Same latency as a normal divide; no trap.
- mthi/mtlo: accepted only in IDLE, written at the accept edge. Visible on hi/lo the next cycle. No busy, no done.
- cancel while busy: return to IDLE next cycle. hi/lo unchanged; done not asserted. cancel in IDLE with no start: no effect.
- hi/lo are stable while busy; they change only at result write, mthi/mtlo, or reset.
- op=0 or op=7 with start=1: no effect.
- Counter: $clog2 of max(MUL_DELAY, DATA_W+1) bits. The counter never wraps: it is loaded at accept and stops at terminal count.

Test Plan (DATA_W=4, MUL_DELAY=2):
- Reset then multu 0xA*0xA -> busy high exactly 2 cycles; done pulse with hi=0x6, lo=0x4; busy=0 same cycle as done.
- mult 0xA(-6)*0x3 -> hi=0xE, lo=0xE (-18). Then start multu 0x5*0x3 while busy -> ignored; result still 0xE/0xE.
- divu 0x7/0x3 -> busy 5 cycles, lo=0x2, hi=0x1. div 0x9(-7)/0x2 -> lo=0xD (-3), hi=0xF (-1). div 0x8/0xF -> lo=0x8, hi=0x0.
- divu 0x5/0x0 and div 0x5/0x0 -> lo=0xF, hi=0x5, normal 5-cycle latency.
- mthi 0xA then mtlo 0x5 on back-to-back cycles -> hi=0xA, lo=0x5, no done. Then div 0x7/0x3 with cancel at its 2nd busy cycle -> IDLE next cycle, no done, hi=0xA, lo=0x5 retained.
- multu 0xF*0xF with reset asserted mid-op -> next cycle busy=0, done=0, hi=0, lo=0. Next accepted op completes normally.
